// File: rtl/pc_redirect_unit.sv
// Fetch PC register with branch/jump redirect, stall-deferred redirect capture,
// pipeline flush strobes, sticky misalignment flag and a saturating taken-branch counter.
module pc_redirect_unit #(
    parameter int unsigned    XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned    CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             jump_en,
    input  logic [XLEN-1:0]  jump_target,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic             pend_state
);

    typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

    state_e          state;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] tgt;
    logic            redirect;
    logic            count_taken;

    assign redirect    = branch_taken | jump_en;
    assign count_taken = branch_taken & ~jump_en;
    assign pc_plus4    = pc + XLEN'(4);
    assign pend_state  = (state == PEND);

    // Jump wins over a simultaneous branch; bit 0 is always cleared (JALR semantics).
    always_comb begin
        tgt    = jump_en ? jump_target : branch_target;
        tgt[0] = 1'b0;
    end

    // In PEND, IF/ID is squashed every cycle (wrong-path fetch); ID/EX only on a fresh redirect.
    always_comb begin
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (rst_n) begin
            case (state)
                RUN: begin
                    flush_if_id = redirect;
                    flush_id_ex = redirect;
                end
                PEND: begin
                    flush_if_id = 1'b1;
                    flush_id_ex = redirect;
                end
                default: begin
                    flush_if_id = 1'b0;
                    flush_id_ex = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            pend_target <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        if (stall) begin
                            pend_target <= tgt;
                            state       <= PEND;
                        end else begin
                            pc <= tgt;
                        end
                    end else if (!stall) begin
                        pc <= pc_plus4;
                    end
                end
                PEND: begin
                    if (redirect) begin
                        pend_target <= tgt;
                    end
                    if (!stall) begin
                        pc    <= redirect ? tgt : pend_target;
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_cnt    <= '0;
            misalign_err <= 1'b0;
        end else begin
            if (count_taken && (taken_cnt != {CNT_W{1'b1}})) begin
                taken_cnt <= taken_cnt + CNT_W'(1);
            end
            if (redirect && tgt[1]) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule
